wb_stage: RTL
=============

# wb_stage

Write-back stage of the 16-bit pipeline: the writing end of the register-bank interface whose reading end is the decode stage. It registers the MEM/WB pipeline state, selects the value to commit, and drives the register bank's write port (write enable, destination register, data). With bypass compiled in, it also forwards the in-flight write value to decode reads. A 16-bit retired-instruction counter is included.

## Interface
- No parameters; widths fixed: data 16 bits, register index 3 bits (8 registers).
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold WB register contents
- flush  in  1  load a bubble at the next edge
- inValid  in  1  MEM stage presents a valid instruction
- inRegWrite  in  1  instruction writes a register
- inWriteReg  in  3  destination register, already selected by RegDst
- inWbSel  in  2  00 ALU result, 01 memory data, 10 link address, 11 extended immediate
- inAluResult  in  16
- inMemData  in  16
- inLinkAddr  in  16
- inImmediate  in  16
- rs, rt  in  3 each  decode-stage source indices (bypass only)
- RegWrite  out  1  register-bank write enable
- writeReg  out  3  register-bank write index
- dataToWrite  out  16  register-bank write data
- fwdHit1, fwdHit2  out  1 each  rs/rt match in-flight write (bypass only)
- fwdData1, fwdData2  out  16 each  forwarded value (bypass only)
- retired  out  16  count of retired instructions

## Operation
- WB register fields: valid, regWrite, writeReg, wbSel, and the four data operands. Each edge: reset has priority; else flush loads valid=0 and regWrite=0; else stall holds; else the register loads all in* fields, with valid=inValid.
- dataToWrite = mux(wbSel) over the registered operands; combinational from the WB register.
- RegWrite = valid & regWrite & (writeReg != 0). Register 0 is never written.
- writeReg and dataToWrite are driven from the register regardless of RegWrite.
- Under stall, the held instruction keeps RegWrite asserted. The repeated write is idempotent and is required behaviour.
- retired increments by 1 on each edge where valid=1 and stall=0. This applies even when flush=1, because flush only kills the incoming instruction. The counter wraps from 0xFFFF to 0x0000.
- Bypass: fwdHit1 = RegWrite & (rs == writeReg), and fwdData1 = dataToWrite. fwdHit2 and fwdData2 are defined the same way using rt.
- Simultaneous flush and stall: flush wins, and the WB register becomes a bubble.

## Timing
- Latency: an instruction captured at edge N drives RegWrite, writeReg and dataToWrite during cycle N to N+1. The register bank commits at edge N+1.
- Outputs are glitch-free functions of the WB register, plus rs/rt for the fwd* outputs. There is no input-to-output combinational path except rs/rt to fwd*.
- Reset (asynchronous, mid-operation included) forces:
  - valid=0, regWrite=0, writeReg=0, wbSel=00, all data operands 0.
  - Resulting outputs: RegWrite=0, writeReg=0, dataToWrite=0, fwdHit*=0, fwdData*=0, retired=0.
- First capture after reset release happens at the first rising edge with reset_n=1.

## Configuration
- WB_BYPASS_EN defined: rs/rt ports and the fwd* outputs exist and behave as above.
- WB_BYPASS_EN undefined: the rs/rt inputs are ignored, and fwdHit1/2=0 and fwdData1/2=0 are driven as constants. The port list is unchanged.

## Structure
- Shared package (processor-wide): the WB_SEL_ALU/MEM/LINK/IMM 2-bit encodings and the DATA_W=16 and REG_W=3 constants. Decode and control reuse them.
- One natural sub-module: wb_mux (4:1 16-bit select on wbSel), instantiated once. Its output feeds both dataToWrite and the bypass outputs. The remaining logic is inline.

## Test plan
- Reset mid-stream: WB holds a valid write to r3. Assert reset_n=0 between edges -> RegWrite=0, dataToWrite=0 and retired=0 immediately, not waiting for an edge.
- Select paths: capture inWbSel=00/01/10/11 with ALU=0x1111, mem=0x2222, link=0x3333, imm=0xFFEA in four consecutive cycles -> dataToWrite follows that sequence one cycle later, and retired advances 0 to 4.
- Register 0 guard: inRegWrite=1, inWriteReg=0, inAluResult=0xBEEF -> RegWrite=0 and fwdHit1=0 with rs=0. retired still increments.
- Stall/flush: capture a write to r5 (0x00A5), then stall for 3 cycles -> RegWrite=1 and retired unchanged throughout. Then assert stall=1 and flush=1 together -> next cycle valid=0, RegWrite=0, and retired unchanged.
- Bypass (WB_BYPASS_EN): WB writes r2=0x7FFF with rs=2, rt=4 -> fwdHit1=1, fwdData1=0x7FFF, fwdHit2=0. Without the macro, all fwd* outputs are 0.
- Counter wrap: preload via 65535 retirements, or force retired to 0xFFFF in the bench. One more retirement -> retired=0x0000.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Processor-wide constants and types shared by decode, control and write-back.
package wb_stage_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 3;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_MEM  = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_IMM  = 2'b11
    } wb_sel_e;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_W-1:0]  write_reg;
        wb_sel_e           wb_sel;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] link_addr;
        logic [DATA_W-1:0] immediate;
    } wb_reg_t;

endpackage

// File: rtl/wb_mux.sv
// 4:1 write-back value select driven by the registered wbSel field.
module wb_mux
    import wb_stage_pkg::*;
(
    input  wb_sel_e           sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_addr,
    input  logic [DATA_W-1:0] immediate,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = alu_result;
        unique case (sel)
            WB_SEL_ALU:  data = alu_result;
            WB_SEL_MEM:  data = mem_data;
            WB_SEL_LINK: data = link_addr;
            WB_SEL_IMM:  data = immediate;
            default:     data = alu_result;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, commit-value select, register-bank write port,
// retired counter. Define WB_BYPASS_EN to forward the in-flight write to decode reads.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              inValid,
    input  logic              inRegWrite,
    input  logic [REG_W-1:0]  inWriteReg,
    input  logic [1:0]        inWbSel,
    input  logic [DATA_W-1:0] inAluResult,
    input  logic [DATA_W-1:0] inMemData,
    input  logic [DATA_W-1:0] inLinkAddr,
    input  logic [DATA_W-1:0] inImmediate,
    input  logic [REG_W-1:0]  rs,
    input  logic [REG_W-1:0]  rt,
    output logic              RegWrite,
    output logic [REG_W-1:0]  writeReg,
    output logic [DATA_W-1:0] dataToWrite,
    output logic              fwdHit1,
    output logic              fwdHit2,
    output logic [DATA_W-1:0] fwdData1,
    output logic [DATA_W-1:0] fwdData2,
    output logic [DATA_W-1:0] retired
);

    wb_reg_t           wb_q, wb_d;
    logic [DATA_W-1:0] retired_q, retired_d;
    logic [DATA_W-1:0] wb_data;
    logic              reg_write;

    // Flush only kills the incoming instruction; unspecified fields keep their value.
    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d.valid     = 1'b0;
            wb_d.reg_write = 1'b0;
        end else if (!stall) begin
            wb_d.valid      = inValid;
            wb_d.reg_write  = inRegWrite;
            wb_d.write_reg  = inWriteReg;
            wb_d.wb_sel     = wb_sel_e'(inWbSel);
            wb_d.alu_result = inAluResult;
            wb_d.mem_data   = inMemData;
            wb_d.link_addr  = inLinkAddr;
            wb_d.immediate  = inImmediate;
        end
    end

    // The instruction held in WB retires as it leaves, independent of flush.
    always_comb begin
        retired_d = retired_q;
        if (wb_q.valid && !stall) begin
            retired_d = retired_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wb_q      <= '0;
            retired_q <= '0;
        end else begin
            wb_q      <= wb_d;
            retired_q <= retired_d;
        end
    end

    wb_mux u_wb_mux (
        .sel        (wb_q.wb_sel),
        .alu_result (wb_q.alu_result),
        .mem_data   (wb_q.mem_data),
        .link_addr  (wb_q.link_addr),
        .immediate  (wb_q.immediate),
        .data       (wb_data)
    );

    // r0 is hard-wired; never raise the bank write enable for it.
    assign reg_write   = wb_q.valid && wb_q.reg_write && (wb_q.write_reg != '0);
    assign RegWrite    = reg_write;
    assign writeReg    = wb_q.write_reg;
    assign dataToWrite = wb_data;
    assign retired     = retired_q;

`ifdef WB_BYPASS_EN
    assign fwdHit1  = reg_write && (rs == wb_q.write_reg);
    assign fwdHit2  = reg_write && (rt == wb_q.write_reg);
    assign fwdData1 = wb_data;
    assign fwdData2 = wb_data;
`else
    logic unused_src;
    assign unused_src = ^{rs, rt};
    assign fwdHit1  = 1'b0;
    assign fwdHit2  = 1'b0;
    assign fwdData1 = '0;
    assign fwdData2 = '0;
`endif

endmodule
